// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared LED width, FSM state encoding and snake length mask helper.
package led_ctrl_pkg;
  localparam int LED_W = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;
  function automatic logic [LED_W-1:0] len_mask(input logic [2:0] sel);
    logic [LED_W-1:0] m;
    for (int i = 0; i < LED_W; i++) m[i] = (i < 2 * (int'(sel) + 1));
    return m;
  endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler that pulses tick once every TICK_DIV enabled cycles.
module led_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV > 2 ? TICK_DIV : 2);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q;
  assign tick = en && (cnt_q == LAST);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/led_snake_ctrl.sv
// led_snake_ctrl: run/pause snake of 2..16 lit LEDs rotating left, with step and lap counters.
module led_snake_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       switch,
  output logic [LED_W-1:0] led,
  output logic [1:0]       state,
  output logic [3:0]       lap
);
  state_e           state_q;
  logic [LED_W-1:0] led_q;
  logic [3:0]       step_q, lap_q;
  logic [2:0]       len_q;
  logic             btn_q, press, tick;
  assign press = button && !btn_q;
  // a press in RUN freezes the prescaler so the pending tick is not lost
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_LOAD),
    .en  (state_q == ST_RUN && !press),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      step_q  <= '0;
      lap_q   <= '0;
      len_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      btn_q <= button;
      case (state_q)
        ST_IDLE: begin
          led_q <= '0;
          if (press) begin
            len_q   <= switch;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          led_q   <= len_mask(len_q);
          step_q  <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (press) state_q <= ST_PAUSE;
          else if (tick) begin
            led_q  <= {led_q[LED_W-2:0], led_q[LED_W-1]};
            step_q <= step_q + 4'd1;
            if (step_q == 4'd15) lap_q <= lap_q + 4'd1;
          end
        end
        default: if (press) state_q <= ST_RUN;
      endcase
    end
  end
  assign led   = led_q;
  assign state = state_q;
  assign lap   = lap_q;
endmodule

// File: tb/tb_led_snake_ctrl.sv
// tb_led_snake_ctrl: directed scenarios plus random run against a rotation-count reference model.
module tb_led_snake_ctrl;
  localparam int TD = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button = 1'b1;
  logic [2:0]  switch = 3'd0;
  logic [15:0] led;
  logic [1:0]  state;
  logic [3:0]  lap;
  int n_vec = 0;
  int n_err = 0;
  int m_st = 0, m_prev = 1, m_n = 2, m_ph = 0, m_ticks = 0, m_lap = 0;
  led_snake_ctrl #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .switch(switch),
    .led   (led),
    .state (state),
    .lap   (lap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_led();
    logic [15:0] v;
    int rot;
    rot = m_ticks % 16;
    for (int i = 0; i < 16; i++) v[i] = (m_st >= 2) && (((i - rot + 16) % 16) < m_n);
    return v;
  endfunction
  task automatic model_step(input logic b, input logic [2:0] sw, input logic r);
    logic p;
    if (r) begin
      m_st = 0; m_lap = 0; m_ticks = 0; m_ph = 0; m_prev = 1;
      return;
    end
    p = b && (m_prev == 0);
    m_prev = int'(b);
    if (m_st == 0) begin
      if (p) begin m_n = 2 * (int'(sw) + 1); m_st = 1; end
    end else if (m_st == 1) begin
      m_ph = 0; m_ticks = 0; m_st = 2;
    end else if (m_st == 2) begin
      if (p) m_st = 3;
      else if (m_ph == TD - 1) begin
        m_ph = 0;
        m_ticks++;
        if (m_ticks % 16 == 0) m_lap = (m_lap + 1) % 16;
      end else m_ph++;
    end else if (p) m_st = 2;
  endtask
  task automatic cyc(input logic b, input logic [2:0] sw, input logic r);
    @(negedge clk);
    button = b; switch = sw; rst = r;
    model_step(b, sw, r);
    @(posedge clk);
    #1;
    chk("led", led, exp_led());
    chk("state", {14'b0, state}, 16'(m_st));
    chk("lap", {12'b0, lap}, 16'(m_lap));
  endtask
  initial begin
    logic [15:0] saved, rotd;
    logic b;
    repeat (3) cyc(1, 0, 1);
    chk("r031_led", led, 16'h0000);
    chk("r031_st", {14'b0, state}, 16'd0);
    repeat (5) cyc(1, 0, 0);
    chk("r031_held", {14'b0, state}, 16'd0);
    cyc(0, 2, 0);
    cyc(1, 2, 0);
    chk("r032_load", {14'b0, state}, 16'd1);
    cyc(1, 5, 0);
    chk("r032_run", {14'b0, state}, 16'd2);
    chk("r032_led0", led, 16'h003F);
    repeat (4) cyc(1, 5, 0);
    chk("r032_led4", led, 16'h007E);
    repeat (4) cyc(1, 5, 0);
    chk("r032_led8", led, 16'h00FC);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (64) cyc(1, 0, 0);
    chk("r033_led", led, 16'h0003);
    chk("r033_lap1", {12'b0, lap}, 16'd1);
    repeat (960) cyc(1, 0, 0);
    chk("r033_lap0", {12'b0, lap}, 16'd0);
    for (int k = 0; k < 8 && m_ph != TD - 1; k++) cyc(0, 0, 0);
    saved = led;
    rotd = {saved[14:0], saved[15]};
    cyc(1, 0, 0);
    chk("r034_pause", {14'b0, state}, 16'd3);
    chk("r034_hold", led, saved);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("r034_resume", {14'b0, state}, 16'd2);
    chk("r034_norot", led, saved);
    cyc(1, 0, 0);
    chk("r034_rot", led, rotd);
    cyc(0, 0, 1);
    cyc(0, 7, 0);
    cyc(1, 7, 0);
    cyc(1, 3'($urandom_range(0, 7)), 0);
    repeat (128) begin
      cyc(1, 3'($urandom_range(0, 7)), 0);
      chk("r035_full", led, 16'hFFFF);
    end
    chk("r035_lap", {12'b0, lap}, 16'd2);
    repeat (64) cyc(1, 1, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("r036_pause", {14'b0, state}, 16'd3);
    chk("r036_lap3", {12'b0, lap}, 16'd3);
    cyc(1, 1, 1);
    chk("r036_led", led, 16'h0000);
    chk("r036_lap", {12'b0, lap}, 16'd0);
    chk("r036_st", {14'b0, state}, 16'd0);
    b = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) b = ~b;
      cyc(b, 3'($urandom_range(0, 7)), $urandom_range(0, 399) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_snake_ctrl.md
LED_SNAKE_CTRL -- requirements
Module: led_snake_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clock cycles per LED step in RUN (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port button, input, 1, the run/pause request, synchronous to clk.
REQ-005 SHALL have port switch, input, 3, the snake length select.
REQ-006 SHALL have port led, output, 16, the registered LED pattern.
REQ-007 SHALL have port state, output, 2, current FSM state: IDLE=0, LOAD=1, RUN=2, PAUSE=3.
REQ-008 SHALL have port lap, output, 4, completed-revolution count.

Function
REQ-009 SHALL detect a press as button==1 while registered btn_q==0; btn_q <= button every cycle.
REQ-010 SHALL define snake length N = 2*(switch+1), giving 2..16, sampled only when a press is detected in IDLE.
REQ-011 SHALL go IDLE->LOAD on the cycle after a press; other IDLE cycles hold led=0x0000.
REQ-012 SHALL spend exactly one cycle in LOAD, then go to RUN.
REQ-013 SHALL, in LOAD, register led = low N bits set (N=6 -> 0x003F), clear the prescaler, and clear the step counter; lap is not cleared.
REQ-014 SHALL, in RUN, increment the prescaler each cycle; tick = (prescaler==TICK_DIV-1), after which the prescaler returns to 0.
REQ-015 SHALL, on tick, rotate led left circularly by one: led <= {led[14:0], led[15]}.
REQ-016 SHALL, on tick, increment the 4-bit step counter; on wrap 15->0, increment lap, which wraps 15->0.
REQ-017 SHALL, on a press in RUN, go to PAUSE; if a tick coincides, the press wins: no rotate, no step, and the prescaler is held.
REQ-018 SHALL, in PAUSE, hold led, prescaler, step counter and lap unchanged.
REQ-019 SHALL, on a press in PAUSE, return to RUN and resume the prescaler from its held value; switch is not resampled.
REQ-020 SHALL ignore switch changes in LOAD, RUN and PAUSE.
REQ-021 SHALL detect no new press while button is held high; one rising edge equals one press.
REQ-022 SHALL, with N=16, keep led=0xFFFF while step and lap still advance per tick.
REQ-023 SHALL, with TICK_DIV=1, tick every RUN cycle.
REQ-024 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, when rst==1 at a clock edge, set led=0x0000, state=IDLE, lap=0, step=0, prescaler=0 and btn_q=1, regardless of state.
REQ-026 SHALL ensure btn_q=1 at reset, so a button held through reset is not a press until released and pressed again.
REQ-027 SHALL give rst priority over a press in the same cycle.

Structure
REQ-028 SHALL place in shared package led_ctrl_pkg: LED_W=16, the state enum with the encodings of REQ-007, and the length-to-mask function.
REQ-029 SHALL implement the prescaler as sub-module led_tick_gen (inputs: clk, rst, clr, en; output: tick), with counter width $clog2 of max(TICK_DIV,2).
REQ-030 SHALL keep FSM, rotate datapath, step counter and lap counter in led_snake_ctrl.

Verification (TICK_DIV=4)
REQ-031 SHALL cover: rst=1 with button=1 held for 3 cycles, then rst=0 with button still 1 -> led=0x0000, state=0, and no transition until button goes 0 then 1.
REQ-032 SHALL cover: switch=2, press -> state=1 next cycle, then led=0x003F with state=2; 4 cycles later led=0x007E, 8 cycles later 0x00FC.
REQ-033 SHALL cover: switch=0, 64 RUN cycles after LOAD -> led back to 0x0003, lap=1; 1024 cycles -> lap=0 (wrap).
REQ-034 SHALL cover: press on the cycle where prescaler==3 -> state=3 with led unchanged; press again -> state=2, and the rotate occurs on the first RUN cycle.
REQ-035 SHALL cover: switch=7, run 128 cycles -> led=0xFFFF throughout, lap=2; changing switch mid-run has no effect.
REQ-036 SHALL cover: rst=1 for one cycle while in PAUSE with lap=3 -> next cycle led=0x0000, lap=0, state=0.
